// File: rtl/sram_rd_seq_if.sv
// rtl/sram_rd_seq_if.sv - command, SRAM read port and output word bundle for sram_rd_seq
interface sram_rd_seq_if #(
    parameter int ENTRYS  = 64,
    parameter int RDWIDTH = 4
);
    localparam int AW = $clog2(ENTRYS);
    localparam int DW = 8 * RDWIDTH;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          re;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    // sequencer side
    modport master (
        input  cmd_valid, cmd_base, cmd_len, rd_data, out_ready,
        output cmd_ready, re, rdaddr, out_valid, out_data, out_last, done
    );

    // command source, SRAM and consumer side
    modport slave (
        output cmd_valid, cmd_base, cmd_len, rd_data, out_ready,
        input  cmd_ready, re, rdaddr, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/sram_rd_seq.sv
// rtl/sram_rd_seq.sv - burst read sequencer from a registered-output SRAM into a 2-entry output buffer
module sram_rd_seq #(
    parameter int ENTRYS  = 64,
    parameter int RDWIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_rd_seq_if.master bus
);
    localparam int AW = $clog2(ENTRYS);
    localparam int DW = 8 * RDWIDTH;

    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEN_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(ENTRYS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic [AW:0]   len_q;
    logic [AW:0]   deliv;
    logic          done_q;

    // One read in flight at most per cycle; it lands in the buffer the cycle after re.
    logic          inflight;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;

    logic          cmd_ready_int;
    logic          accept;
    logic          pop;
    logic          issue;
    logic [1:0]    load;
    logic [AW-1:0] next_ptr;
    logic          is_last_word;

    // Gating with rst keeps cmd_ready low for the whole reset, not just after the first edge.
    assign cmd_ready_int = (state == IDLE) && !rst;
    assign accept        = bus.cmd_valid && cmd_ready_int;
    assign pop           = (occ != 2'd0) && bus.out_ready;

    // Words that will still hold a buffer slot next cycle: buffered plus in flight, less this pop.
    assign load     = occ + {1'b0, inflight} - {1'b0, pop};
    assign issue    = (state == RUN) && (load < 2'd2);
    assign next_ptr = (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;

    assign is_last_word = (deliv == len_q - LEN_ONE);

    assign bus.cmd_ready = cmd_ready_int;
    assign bus.re        = issue;
    assign bus.rdaddr    = ptr;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.out_last  = (occ != 2'd0) && is_last_word;
    assign bus.done      = done_q;

    // Burst control FSM: command latch, issue pointer/counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.cmd_len == LEN_ZERO) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            ptr       <= bus.cmd_base;
                            remaining <= bus.cmd_len;
                            len_q     <= bus.cmd_len;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        ptr       <= next_ptr;
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && is_last_word) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delivered-word index within the current burst, drives out_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deliv <= '0;
        end else if (accept) begin
            deliv <= '0;
        end else if (pop) begin
            deliv <= deliv + LEN_ONE;
        end
    end

    // Buffer bookkeeping: capture follows every re by one cycle regardless of out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Buffer storage; contents are meaningless until occ marks them valid, so no reset.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= bus.rd_data;
        end
    end
endmodule

// File: tb/tb_sram_rd_seq.sv
// tb/tb_sram_rd_seq.sv - self-checking bench for sram_rd_seq
module tb_sram_rd_seq;
    localparam int ENTRYS  = 64;
    localparam int RDWIDTH = 4;
    localparam int AW      = $clog2(ENTRYS);
    localparam int DW      = 8 * RDWIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_rd_seq_if #(.ENTRYS(ENTRYS), .RDWIDTH(RDWIDTH)) bus ();

    sram_rd_seq #(.ENTRYS(ENTRYS), .RDWIDTH(RDWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SRAM with registered data_out
    logic [DW-1:0] mem [ENTRYS];
    always @(posedge clk) begin
        if (bus.re) bus.rd_data <= mem[bus.rdaddr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    int cyc = 0;
    int acc_cyc = 0;
    int ready_mode = 0;
    int stall_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // consumer: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled for stall_cyc cycles
    initial begin
        int rel;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rel = cyc - acc_cyc;
            case (ready_mode)
                1:       bus.out_ready = (rel < 0) || (rel % 4 == 0) || (rel % 4 == 3);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                3:       bus.out_ready = (rel >= stall_cyc);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // reference model: expected addresses/words of the accepted burst, delivery bookkeeping
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int issued = 0, delivered = 0;
    bit busy = 0, done_exp = 0, prev_stall = 0, burst_done = 0;
    logic [DW-1:0] prev_data;
    int re_cnt, deliv_cnt, first_re_rel, last_re_rel, first_valid_rel, done_rel, stall_re;

    always @(negedge clk) begin
        int  rel;
        bit  pop;
        int  a;
        if (rst) begin
            exp_addr.delete();
            exp_data.delete();
            issued = 0; delivered = 0;
            busy = 0; done_exp = 0; prev_stall = 0;
        end else begin
            rel = cyc - acc_cyc;
            pop = bus.out_valid && bus.out_ready;
            chk("done", bus.done, done_exp);
            if (bus.done) begin burst_done = 1; done_rel = rel; end
            chk("cmd_ready", bus.cmd_ready, !busy);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            chk("out_last", bus.out_last, bus.out_valid && (exp_data.size() == 1));
            if (bus.out_valid) chk("valid_spurious", exp_data.size() != 0, 1);
            done_exp = 0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc = cyc + 1;
                re_cnt = 0; deliv_cnt = 0; stall_re = 0;
                first_re_rel = -1; last_re_rel = -1; first_valid_rel = -1; done_rel = -1;
                for (int k = 0; k < int'(bus.cmd_len); k++) begin
                    a = (int'(bus.cmd_base) + k) % ENTRYS;
                    exp_addr.push_back(AW'(a));
                    exp_data.push_back(mem[a]);
                end
                if (bus.cmd_len == 0) done_exp = 1;
                else busy = 1;
            end
            if (bus.re) begin
                chk("re_load", (issued - delivered - int'(pop)) < 2, 1);
                chk("re_unexpected", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) chk("rdaddr", bus.rdaddr, exp_addr.pop_front());
                issued++; re_cnt++;
                if (first_re_rel < 0) first_re_rel = rel;
                last_re_rel = rel;
                if (ready_mode == 3 && rel < stall_cyc) stall_re++;
            end
            if (bus.out_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (pop && exp_data.size() > 0) begin
                chk("out_data", bus.out_data, exp_data[0]);
                if (exp_data.size() == 1) begin busy = 0; done_exp = 1; end
                void'(exp_data.pop_front());
                delivered++; deliv_cnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic run_burst(input int base, input int len, input int mode, input int stall);
        int n;
        ready_mode = mode; stall_cyc = stall; burst_done = 0;
        @(posedge clk); #1;
        bus.cmd_base = AW'(base); bus.cmd_len = (AW+1)'(len); bus.cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 100);
        chk("accept_timeout", bus.cmd_ready, 1);
        @(posedge clk); #1;
        // junk commands while busy must be ignored
        for (int j = 0; j < ((len < 4) ? len : 4); j++) begin
            bus.cmd_base = AW'($urandom); bus.cmd_len = (AW+1)'($urandom);
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!burst_done && n < 3000) begin @(negedge clk); n++; end
        chk("done_timeout", burst_done, 1);
        @(negedge clk);
    endtask

    task automatic burst_checks(input int len, input int mode, input int exp_done_rel, input int exp_stall_re);
        chk("words", deliv_cnt, len);
        chk("re_count", re_cnt, len);
        if (exp_done_rel >= 0) chk("done_rel", done_rel, exp_done_rel);
        if (exp_stall_re >= 0) chk("stall_re", stall_re, exp_stall_re);
        if (mode == 0 && len > 0) begin
            chk("first_re_rel", first_re_rel, 0);
            chk("last_re_rel", last_re_rel, len - 1);
            chk("first_valid_rel", first_valid_rel, 2);
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int stall;
        int exp_words;
        int exp_done_rel;
        int exp_stall_re;
    } vec_t;

    vec_t vt [7];

    initial begin
        int base, len, mode, stall, dr, sr;
        vt[0] = '{0,  8,  0, 0,  8,  10, -1};
        vt[1] = '{62, 4,  0, 0,  4,  6,  -1};
        vt[2] = '{0,  8,  1, 0,  8,  -1, -1};
        vt[3] = '{0,  0,  0, 0,  0,  0,  -1};
        vt[4] = '{5,  64, 3, 10, 64, -1, 2};
        vt[5] = '{63, 1,  0, 0,  1,  3,  -1};
        vt[6] = '{10, 3,  3, 5,  3,  -1, 2};

        for (int i = 0; i < ENTRYS; i++) mem[i] = DW'(i);
        bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
        rst = 1'b1;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_re", bus.re, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdaddr", bus.rdaddr, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", bus.cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_burst(vt[i].base, vt[i].len, vt[i].mode, vt[i].stall);
            chk("vec_words", deliv_cnt, vt[i].exp_words);
            burst_checks(vt[i].len, vt[i].mode, vt[i].exp_done_rel, vt[i].exp_stall_re);
        end

        // reset mid-burst, asserted between clock edges
        ready_mode = 0;
        @(posedge clk); #1;
        bus.cmd_base = '0; bus.cmd_len = (AW+1)'(16); bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
        chk("mid_rst_re", bus.re, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_rdaddr", bus.rdaddr, 0);
        @(posedge clk); #2;
        chk("hold_rst_out_valid", bus.out_valid, 0);
        chk("hold_rst_re", bus.re, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_mid_rst", bus.cmd_ready, 1);
        chk("no_capture_after_rst", bus.out_valid, 0);
        run_burst(0, 2, 0, 0);
        burst_checks(2, 0, 4, -1);

        // randomized bursts against the model
        for (int i = 0; i < ENTRYS; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 25; t++) begin
            base  = $urandom_range(0, ENTRYS - 1);
            len   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, ENTRYS);
            mode  = $urandom_range(0, 3);
            stall = $urandom_range(0, 15);
            run_burst(base, len, mode, stall);
            if (len == 0) dr = 0;
            else if (mode == 0) dr = len + 2;
            else dr = -1;
            sr = -1;
            if (mode == 3) begin
                sr = len;
                if (sr > 2) sr = 2;
                if (sr > stall) sr = stall;
            end
            burst_checks(len, mode, dr, sr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_rd_seq.md
SRAM_RD_SEQ -- requirements
Module: sram_rd_seq

Interface
REQ-001 The module SHALL have parameter ENTRYS, default 64, meaning the number of words in the SRAM read port it drives; AW = $clog2(ENTRYS).
REQ-002 The module SHALL have parameter RDWIDTH, default 4, meaning the bits per lane; the lane count SHALL be fixed at 8.
REQ-003 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1 bit: a read-burst command is offered.
REQ-007 Port cmd_ready, output, 1 bit: the sequencer accepts a command when this and cmd_valid are both high.
REQ-008 Port cmd_base, input, AW bits: first SRAM address of the burst.
REQ-009 Port cmd_len, input, AW+1 bits: number of words to read, from 0 to ENTRYS.
REQ-010 Port re, output, 1 bit: SRAM read enable.
REQ-011 Port rdaddr, output, AW bits: SRAM read address, valid while re is high.
REQ-012 Port rd_data, input, 8x RDWIDTH bits: SRAM data_out, registered one cycle after re.
REQ-013 Port out_valid, output, 1 bit: out_data holds a word.
REQ-014 Port out_ready, input, 1 bit: the consumer takes the word when this and out_valid are both high.
REQ-015 Port out_data, output, 8x RDWIDTH bits: the word being presented, lane i taken from rd_data lane i.
REQ-016 Port out_last, output, 1 bit: high with out_valid on the final word of the burst.
REQ-017 Port done, output, 1 bit: one-cycle pulse when the burst completes.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-019 On command acceptance with cmd_len>0, the FSM SHALL go IDLE->RUN and latch the address pointer to cmd_base and the remaining-issue counter to cmd_len.
REQ-020 On command acceptance with cmd_len==0, the FSM SHALL stay in IDLE, issue no re, and pulse done on the next cycle.
REQ-021 In RUN, re SHALL be asserted only when the outstanding reads (issued, data not yet captured) plus the occupied output-buffer entries are fewer than 2.
REQ-022 Each re SHALL present rdaddr equal to the pointer; the pointer SHALL then increment modulo ENTRYS (ENTRYS-1 wraps to 0), and the remaining-issue counter SHALL decrement.
REQ-023 rd_data SHALL be captured into a 2-entry FIFO exactly one cycle after each re, independent of out_ready.
REQ-024 The module SHALL never drop or duplicate a word under any out_ready pattern; the FIFO SHALL never overflow.
REQ-025 out_valid SHALL equal FIFO non-empty and out_data SHALL equal the FIFO head; both SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-027 A delivered-word counter SHALL assert out_last on the word whose delivery index equals len-1.
REQ-028 When the last re issues, the FSM SHALL go RUN->DRAIN.
REQ-029 The DRAIN->IDLE transition SHALL occur on the handshake of the word with out_last=1; done SHALL pulse in the following cycle, and cmd_ready SHALL be high in that same cycle.
REQ-030 With out_ready held at 1, re SHALL assert every cycle of the burst; the first word SHALL appear on out_valid 2 cycles after command acceptance; throughput SHALL be 1 word/cycle.
REQ-031 cmd_base, cmd_len and cmd_valid SHALL be ignored outside IDLE.

Reset
REQ-032 While rst is high, the following outputs SHALL be 0 immediately, without waiting for a clock: cmd_ready, re, out_valid, out_last and done.
REQ-033 While rst is high, rdaddr SHALL be 0, the FSM SHALL be in IDLE, and the counters and FIFO pointers SHALL be cleared.
REQ-034 The cycle after rst deasserts, cmd_ready SHALL be 1.
REQ-035 A burst interrupted by reset SHALL be discarded; a capture of in-flight rd_data SHALL not occur after reset.

Verification
REQ-036 Scenario: ENTRYS=64, cmd_base=0, cmd_len=8, out_ready=1, SRAM model words 0..7 -> re high for 8 consecutive cycles with rdaddr=0..7; out_data sequence 0..7; out_last on the 8th word; done 1 cycle after it.
REQ-037 Scenario: cmd_base=62, cmd_len=4 -> rdaddr sequence 62,63,0,1.
REQ-038 Scenario: cmd_len=8 with out_ready toggling 1,0,0,1 repeatedly -> all 8 words delivered in order, no duplicates; out_data stable during stalls; re never issued with 2 outstanding or buffered words.
REQ-039 Scenario: cmd_len=0 -> no re; done pulses 1 cycle after acceptance; cmd_ready is 1 throughout.
REQ-040 Scenario: cmd_len=64, base=5, out_ready=0 for 10 cycles and then 1 -> exactly 2 re issued during the stall; all 64 words delivered, addresses 5..63 then 0..4.
REQ-041 Scenario: rst asserted mid-burst, asynchronously to clk -> outputs go to 0 at once; after release cmd_ready=1, and a new burst with cmd_base=0, cmd_len=2 delivers words 0,1 correctly.
